// File: rtl/seq_div_32.sv
// Multi-cycle signed/unsigned divider, non-restoring, one quotient bit per cycle.
// Quotient goes to Zlow and remainder to Zhigh; start/busy/done handshake.
module seq_div_32 #(
    parameter int WIDTH = 32
) (
    input  logic             Clock,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;      // captured operands
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             sgn_op_q, sgn_op_d;
    logic [WIDTH:0]   p_q, p_d;          // signed partial remainder, one guard bit
    logic [WIDTH-1:0] a_q, a_d;          // |dividend|, becomes quotient magnitude
    logic [WIDTH-1:0] d_q, d_d;          // |divisor|
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH:0]   d_ext;
    logic [WIDTH:0]   p_sh;
    logic [WIDTH:0]   p_nx;
    logic [WIDTH:0]   p_fix;
    logic [WIDTH-1:0] r_mag;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d  = state_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        sgn_op_d = sgn_op_q;
        p_d      = p_q;
        a_d      = a_q;
        d_d      = d_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        cnt_d    = cnt_q;
        quot_d   = quot_q;
        rem_d    = rem_q;
        dbz_d    = dbz_q;

        // The add/subtract choice uses the sign of P before the shift; the 33-bit
        // wrap on the shifted value is harmless because the result fits again.
        d_ext = {1'b0, d_q};
        p_sh  = {p_q[WIDTH-1:0], a_q[WIDTH-1]};
        p_nx  = p_q[WIDTH] ? (p_sh + d_ext) : (p_sh - d_ext);
        p_fix = p_q[WIDTH] ? (p_q + d_ext) : p_q;
        r_mag = p_fix[WIDTH-1:0];

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d    = dividend;
                    dvs_d    = divisor;
                    sgn_op_d = signed_op;
                    dbz_d    = 1'b0;
                    state_d  = S_PREP;
                end
            end
            S_PREP: begin
                if (dvs_q == '0) begin
                    quot_d  = '1;
                    rem_d   = dvd_q;
                    dbz_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    a_d     = (sgn_op_q && dvd_q[WIDTH-1]) ? -dvd_q : dvd_q;
                    d_d     = (sgn_op_q && dvs_q[WIDTH-1]) ? -dvs_q : dvs_q;
                    qneg_d  = sgn_op_q && (dvd_q[WIDTH-1] ^ dvs_q[WIDTH-1]);
                    rneg_d  = sgn_op_q && dvd_q[WIDTH-1];
                    p_d     = '0;
                    cnt_d   = '0;
                    state_d = S_ITER;
                end
            end
            S_ITER: begin
                p_d   = p_nx;
                a_d   = {a_q[WIDTH-2:0], ~p_nx[WIDTH]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                p_d     = p_fix;
                quot_d  = qneg_q ? -a_q : a_q;
                rem_d   = rneg_q ? -r_mag : r_mag;
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: the whole datapath is reset, not just control, so an aborted divide leaves no trace.
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            dvd_q    <= '0;
            dvs_q    <= '0;
            sgn_op_q <= 1'b0;
            p_q      <= '0;
            a_q      <= '0;
            d_q      <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            cnt_q    <= '0;
            quot_q   <= '0;
            rem_q    <= '0;
            dbz_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge _d values.
            state_q  <= state_d;
            dvd_q    <= dvd_d;
            dvs_q    <= dvs_d;
            sgn_op_q <= sgn_op_d;
            p_q      <= p_d;
            a_q      <= a_d;
            d_q      <= d_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            cnt_q    <= cnt_d;
            quot_q   <= quot_d;
            rem_q    <= rem_d;
            dbz_q    <= dbz_d;
        end
    end

    assign busy        = (state_q == S_PREP) || (state_q == S_ITER) || (state_q == S_FIX);
    assign done        = (state_q == S_DONE);
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_div_32.sv
// Bench for seq_div_32: arithmetic reference model checked every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_seq_div_32;

    logic        Clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic [31:0] dividend = '0;
    logic [31:0] divisor = '0;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int n_vec = 0;
    int n_err = 0;

    seq_div_32 dut (
        .Clock      (Clock),
        .reset      (reset),
        .start      (start),
        .signed_op  (signed_op),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Plain-arithmetic reference: 64-bit division avoids the signed overflow trap.
    function automatic logic [63:0] ref_div(input logic sd, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] qv, rv;
        if (b == 32'd0) return {32'hFFFF_FFFF, a};
        if (sd) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q  = sa / sb;
        r  = sa % sb;
        qv = q;
        rv = r;
        return {qv[31:0], rv[31:0]};
    endfunction

    // Transaction-level timing model: done appears 35 cycles after acceptance (2 for divide by zero).
    logic        m_busy, m_done, m_dbz, m_pdbz;
    logic [31:0] m_q, m_r, m_pq, m_pr;
    int          m_left;

    always @(posedge Clock or negedge reset) begin
        if (!reset) begin
            m_busy = 1'b0; m_done = 1'b0; m_dbz = 1'b0; m_pdbz = 1'b0;
            m_q = '0; m_r = '0; m_pq = '0; m_pr = '0; m_left = 0;
        end else if (m_done) begin
            m_done = 1'b0;
        end else if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 1'b0;
                m_done = 1'b1;
                m_q    = m_pq;
                m_r    = m_pr;
                m_dbz  = m_pdbz;
            end
        end else if (start) begin
            m_busy     = 1'b1;
            m_left     = (divisor == 32'd0) ? 1 : 34;
            {m_pq, m_pr} = ref_div(signed_op, dividend, divisor);
            m_pdbz     = (divisor == 32'd0);
            m_dbz      = 1'b0;
        end
    end

    always @(posedge Clock) begin
        #1;
        check("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
        check("cyc_done", {31'd0, done}, {31'd0, m_done});
        check("cyc_dbz", {31'd0, div_by_zero}, {31'd0, m_dbz});
        check("cyc_quotient", quotient, m_q);
        check("cyc_remainder", remainder, m_r);
    end

    task automatic wait_idle();
        int guard = 0;
        while ((busy || done) && guard < 100) begin
            @(negedge Clock);
            guard++;
        end
        @(negedge Clock);
    endtask

    // Launch one divide; optionally pulse a stray start (9/3) at cycle inj_at.
    task automatic run_op(input string name, input logic sd, input logic [31:0] a, input logic [31:0] b,
                          input bit lit, input logic [31:0] eq, input logic [31:0] er,
                          input logic edbz, input int elat, input int inj_at);
        int lat;
        wait_idle();
        signed_op = sd; dividend = a; divisor = b; start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        lat = 1;
        while (!done && lat < 100) begin
            @(negedge Clock);
            lat++;
            if (lat == inj_at) begin
                start = 1'b1; dividend = 32'd9; divisor = 32'd3;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        if (lit) begin
            check({name, "_latency"}, 32'(lat), 32'(elat));
            check({name, "_quotient"}, quotient, eq);
            check({name, "_remainder"}, remainder, er);
            check({name, "_dbz"}, {31'd0, div_by_zero}, {31'd0, edbz});
        end else begin
            check({name, "_done_seen"}, {31'd0, done}, 32'd1);
        end
    endtask

    initial begin
        repeat (3) @(negedge Clock);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_quotient", quotient, 32'd0);
        check("reset_remainder", remainder, 32'd0);
        reset = 1'b1;
        @(negedge Clock);

        run_op("u24_20", 1'b0, 32'h18, 32'h14, 1, 32'h1, 32'h4, 1'b0, 35, 0);
        run_op("u18_20", 1'b0, 32'h12, 32'h14, 1, 32'h0, 32'h12, 1'b0, 35, 0);
        run_op("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h2, 1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 35, 0);
        run_op("s_7_m2", 1'b1, 32'h7, 32'hFFFF_FFFE, 1, 32'hFFFF_FFFD, 32'h1, 1'b0, 35, 0);
        run_op("dbz", 1'b0, 32'h1234, 32'h0, 1, 32'hFFFF_FFFF, 32'h1234, 1'b1, 2, 0);
        run_op("after_dbz", 1'b0, 32'd100, 32'd7, 1, 32'd14, 32'd2, 1'b0, 35, 0);
        run_op("stray_start", 1'b0, 32'd100, 32'd7, 1, 32'd14, 32'd2, 1'b0, 35, 10);

        // A start pulsed during the done cycle must not launch a new divide.
        start = 1'b1; dividend = 32'd8; divisor = 32'd2;
        @(negedge Clock);
        start = 1'b0;
        check("start_in_done_busy", {31'd0, busy}, 32'd0);

        run_op("s_overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h8000_0000, 32'h0, 1'b0, 35, 0);
        run_op("u_max_2", 1'b0, 32'hFFFF_FFFF, 32'h2, 1, 32'h7FFF_FFFF, 32'h1, 1'b0, 35, 0);
        run_op("u_msb_big", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 1, 32'h0, 32'h8000_0000, 1'b0, 35, 0);
        run_op("s_m100_m7", 1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 1, 32'hE, 32'hFFFF_FFFE, 1'b0, 35, 0);
        run_op("s_dbz_neg", 1'b1, 32'hFFFF_FF00, 32'h0, 1, 32'hFFFF_FFFF, 32'hFFFF_FF00, 1'b1, 2, 0);

        // Reset in the middle of an operation discards it.
        wait_idle();
        signed_op = 1'b0; dividend = 32'd100; divisor = 32'd7; start = 1'b1;
        @(negedge Clock);
        start = 1'b0;
        repeat (19) @(negedge Clock);
        reset = 1'b0;
        @(negedge Clock);
        check("midreset_busy", {31'd0, busy}, 32'd0);
        check("midreset_done", {31'd0, done}, 32'd0);
        check("midreset_quotient", quotient, 32'd0);
        check("midreset_remainder", remainder, 32'd0);
        check("midreset_dbz", {31'd0, div_by_zero}, 32'd0);
        reset = 1'b1;
        repeat (20) @(negedge Clock);
        check("midreset_no_done", {31'd0, done}, 32'd0);
        run_op("after_reset", 1'b0, 32'd50, 32'd5, 1, 32'd10, 32'd0, 1'b0, 35, 0);

        for (int i = 0; i < 6; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = (i % 2 == 0) ? 32'($urandom_range(1, 1000)) : $urandom;
            run_op("rand", 1'(i % 3 != 0), ra, rb, 0, 32'd0, 32'd0, 1'b0, 0, 0);
        end

        repeat (3) @(negedge Clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
